// File: rtl/key_conditioner.sv
// Button front-end for the guess-number game: synchronizes and debounces four number
// keys plus enter, then arbitrates them into one-hot, single-cycle press pulses.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       enter_raw,
    output logic [3:0] key_pulse,
    output logic       enter_pulse,
    output logic [3:0] key_last,
    output logic       any_held,
    output logic [7:0] press_count
);

    localparam int                N_IN     = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_HELD
    } state_t;

    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] sync1_q;
    logic [N_IN-1:0] sync_q;
    logic [N_IN-1:0] deb_q;
    logic [N_IN-1:0] deb_d;
    logic [N_IN-1:0] deb_dly_q;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] pick;

    state_t     state_q, state_d;
    logic [3:0] key_pulse_q, key_pulse_d;
    logic       enter_pulse_q, enter_pulse_d;
    logic [3:0] key_last_q, key_last_d;
    logic [7:0] press_count_q, press_count_d;
    logic       any_held_q;

    assign raw_in = {enter_raw, btn_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= raw_in;
            sync_q  <= sync1_q;
        end
    end

    // Each input owns a counter that only runs while its synchronized level disagrees
    // with the debounced level; any agreement (a bounce) restarts it from zero.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             differ;

        assign differ     = sync_q[gi] ^ deb_q[gi];
        assign cnt_d      = (differ && (cnt_q != CNT_LAST)) ? cnt_q + CNT_W'(1) : '0;
        assign deb_d[gi]  = (differ && (cnt_q == CNT_LAST)) ? sync_q[gi] : deb_q[gi];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q     <= '0;
            deb_dly_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

    assign rise = deb_q & ~deb_dly_q;
    // Lowest set bit wins, so key 1 beats key 4 and every number key beats enter.
    assign pick = rise & (~rise + 5'd1);

    always_comb begin
        state_d       = state_q;
        key_pulse_d   = '0;
        enter_pulse_d = 1'b0;
        key_last_d    = key_last_q;
        press_count_d = press_count_q;
        case (state_q)
            S_IDLE: begin
                if (|rise) begin
                    state_d       = S_HELD;
                    key_pulse_d   = pick[3:0];
                    enter_pulse_d = pick[4];
                    press_count_d = press_count_q + 8'd1;
                    if (|pick[3:0]) begin
                        key_last_d = pick[3:0];
                    end
                end
            end
            S_HELD: begin
                // Rises seen here are dropped for good; a fresh press is needed later.
                if (deb_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            key_pulse_q   <= '0;
            enter_pulse_q <= 1'b0;
            key_last_q    <= '0;
            press_count_q <= '0;
            any_held_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_pulse_q   <= key_pulse_d;
            enter_pulse_q <= enter_pulse_d;
            key_last_q    <= key_last_d;
            press_count_q <= press_count_d;
            any_held_q    <= |deb_q;
        end
    end

    assign key_pulse   = key_pulse_q;
    assign enter_pulse = enter_pulse_q;
    assign key_last    = key_last_q;
    assign any_held    = any_held_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a short debounce window: a vector table of
// press/release steps plus hand sequences for latency, bounce, wrap and async reset.
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int NV  = 17;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       enter_raw = 1'b0;
    logic [3:0] key_pulse;
    logic       enter_pulse;
    logic [3:0] key_last;
    logic       any_held;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    int         kp_cnt;
    int         ep_cnt;
    int         viol;
    logic [3:0] kp_or;

    typedef struct {
        logic [3:0] btn;
        logic       ent;
        logic [3:0] exp_kor;
        int         exp_kcnt;
        int         exp_ecnt;
        logic [3:0] exp_last;
        logic [7:0] exp_count;
        logic       exp_held;
    } vec_t;

    vec_t vecs[NV];

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .enter_raw(enter_raw),
        .key_pulse(key_pulse),
        .enter_pulse(enter_pulse),
        .key_last(key_last),
        .any_held(any_held),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        kp_cnt = 0;
        ep_cnt = 0;
        viol   = 0;
        kp_or  = 4'b0000;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (key_pulse != 4'b0000) begin
            kp_cnt++;
            kp_or = kp_or | key_pulse;
        end
        if (enter_pulse) ep_cnt++;
        if ($countones({key_pulse, enter_pulse}) > 1) viol++;
    endtask

    task automatic apply_reset();
        btn_raw   = 4'b0000;
        enter_raw = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 1, 0, 4'b0100, 8'd1, 1'b1};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b0100, 8'd1, 1'b0};
        vecs[2]  = '{4'b1000, 1'b1, 4'b1000, 1, 0, 4'b1000, 8'd2, 1'b1};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 0, 0, 4'b1000, 8'd2, 1'b1};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b1000, 8'd2, 1'b0};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 0, 1, 4'b1000, 8'd3, 1'b1};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b1000, 8'd3, 1'b0};
        vecs[7]  = '{4'b0001, 1'b0, 4'b0001, 1, 0, 4'b0001, 8'd4, 1'b1};
        vecs[8]  = '{4'b0011, 1'b0, 4'b0000, 0, 0, 4'b0001, 8'd4, 1'b1};
        vecs[9]  = '{4'b0001, 1'b0, 4'b0000, 0, 0, 4'b0001, 8'd4, 1'b1};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b0001, 8'd4, 1'b0};
        vecs[11] = '{4'b0010, 1'b0, 4'b0010, 1, 0, 4'b0010, 8'd5, 1'b1};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b0010, 8'd5, 1'b0};
        vecs[13] = '{4'b1111, 1'b1, 4'b0001, 1, 0, 4'b0001, 8'd6, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b0001, 8'd6, 1'b0};
        vecs[15] = '{4'b0110, 1'b0, 4'b0010, 1, 0, 4'b0010, 8'd7, 1'b1};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 0, 0, 4'b0010, 8'd7, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_pulse", key_pulse, 0);
        check("rst_enter_pulse", enter_pulse, 0);
        check("rst_key_last", key_last, 0);
        check("rst_any_held", any_held, 0);
        check("rst_press_count", press_count, 0);
        reset = 1'b0;
        tick();

        // Exact latency: input sampled at edge 0, pulse visible after edge 2+DEB
        btn_raw = 4'b0100;
        clear_mon();
        repeat (6) tick();
        check("lat_no_early_pulse", kp_cnt, 0);
        check("lat_held_early", any_held, 0);
        tick();
        check("lat_pulse", key_pulse, 4'b0100);
        check("lat_key_last", key_last, 4'b0100);
        check("lat_count", press_count, 1);
        check("lat_held", any_held, 1);
        tick();
        check("lat_pulse_width", key_pulse, 0);
        btn_raw = 4'b0000;
        repeat (6) tick();
        check("rel_held_still", any_held, 1);
        tick();
        check("rel_held_clear", any_held, 0);
        check("rel_no_pulse", kp_cnt, 1);
        repeat (2) tick();

        // Vector table
        apply_reset();
        for (int i = 0; i < NV; i++) begin
            btn_raw   = vecs[i].btn;
            enter_raw = vecs[i].ent;
            clear_mon();
            repeat (12) tick();
            $display("vec %0d btn=%b ent=%b keys=%b kcnt=%0d ecnt=%0d last=%b count=%0d held=%b",
                     i, vecs[i].btn, vecs[i].ent, kp_or, kp_cnt, ep_cnt, key_last, press_count, any_held);
            check($sformatf("v%0d_keys", i), kp_or, vecs[i].exp_kor);
            check($sformatf("v%0d_kcnt", i), kp_cnt, vecs[i].exp_kcnt);
            check($sformatf("v%0d_ecnt", i), ep_cnt, vecs[i].exp_ecnt);
            check($sformatf("v%0d_last", i), key_last, vecs[i].exp_last);
            check($sformatf("v%0d_count", i), press_count, vecs[i].exp_count);
            check($sformatf("v%0d_held", i), any_held, vecs[i].exp_held);
            check($sformatf("v%0d_onehot", i), viol, 0);
        end

        // Bounce: 2-cycle toggles never satisfy the 4-cycle window
        apply_reset();
        clear_mon();
        for (int p = 0; p < 10; p++) begin
            btn_raw = (p % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (2) tick();
        end
        btn_raw = 4'b0001;
        repeat (6) tick();
        check("bounce_quiet", kp_cnt, 0);
        tick();
        check("bounce_pulse", key_pulse, 4'b0001);
        repeat (10) tick();
        check("bounce_once", kp_cnt, 1);
        $display("bounce: pulses=%0d count=%0d", kp_cnt, press_count);
        btn_raw = 4'b0000;
        repeat (8) tick();

        // Wrap of press_count after 256 accepted presses
        apply_reset();
        clear_mon();
        for (int i = 0; i < 256; i++) begin
            btn_raw = 4'b0001 << (i % 4);
            repeat (8) tick();
            btn_raw = 4'b0000;
            repeat (8) tick();
            if (i == 254) check("wrap_255", press_count, 255);
        end
        check("wrap_zero", press_count, 0);
        check("wrap_last", key_last, 4'b1000);
        check("wrap_pulses", kp_cnt, 256);
        $display("wrap: pulses=%0d count=%0d last=%b", kp_cnt, press_count, key_last);

        // Async reset mid-HELD while a pulse is in flight, key held through reset
        apply_reset();
        btn_raw = 4'b1000;
        repeat (7) tick();
        check("inflight_pre", key_pulse, 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        check("async_key_pulse", key_pulse, 0);
        check("async_key_last", key_last, 0);
        check("async_count", press_count, 0);
        check("async_held", any_held, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        clear_mon();
        repeat (6) tick();
        check("held_thru_quiet", kp_cnt, 0);
        tick();
        check("held_thru_pulse", key_pulse, 4'b1000);
        repeat (8) tick();
        check("held_thru_once", kp_cnt, 1);
        check("held_thru_count", press_count, 1);
        $display("reset-held: pulses=%0d count=%0d", kp_cnt, press_count);

        // Async reset mid-debounce, input gone by reset release
        btn_raw = 4'b0000;
        repeat (8) tick();
        btn_raw = 4'b0010;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check("middeb_count", press_count, 0);
        check("middeb_last", key_last, 0);
        btn_raw = 4'b0000;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        clear_mon();
        repeat (12) tick();
        check("middeb_no_pulse", kp_cnt, 0);
        $display("reset-debounce: pulses=%0d count=%0d", kp_cnt, press_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
